// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus initiator and its address decoder.
// Contents:
//   - bus widths and latency counter width
//   - default peripheral window (base address / span)
//   - register offsets of the timer peripheral (CONTROL, TIM_CNT, COMPARE, PRESCALER)
//   - FSM state enum pbi_state_t
//   - response payload struct pbi_rsp_t
//   - word-alignment helper
package periph_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT_W  = 3;

  localparam logic [ADDR_W-1:0] PBI_DEFAULT_BASE_ADDR   = 32'h4000_0000;
  localparam logic [ADDR_W-1:0] PBI_DEFAULT_WINDOW_SPAN = 32'h0000_0100;

  // Timer peripheral register offsets within the window
  localparam logic [ADDR_W-1:0] REG_CONTROL   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] REG_TIM_CNT   = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] REG_COMPARE   = 32'h0000_0008;
  localparam logic [ADDR_W-1:0] REG_PRESCALER = 32'h0000_000C;

  typedef enum logic [1:0] {
    PBI_IDLE   = 2'd0,
    PBI_STROBE = 2'd1,
    PBI_WAIT   = 2'd2,
    PBI_RESP   = 2'd3
  } pbi_state_t;

  // Response beat returned to the core
  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } pbi_rsp_t;

  // Peripheral registers are 32-bit words; byte/halfword offsets are rejected
  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational window decode for one peripheral slave.
// Ports:
//   addr      in  32  byte address from the core
//   offset    out 32  addr - BASE_ADDR (full-width, upper bits 0 when in window)
//   in_window out 1   addr lies in [BASE_ADDR, BASE_ADDR + WINDOW_SPAN)
//   aligned   out 1   addr is word aligned
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = PBI_DEFAULT_BASE_ADDR,
  parameter logic [ADDR_W-1:0] WINDOW_SPAN = PBI_DEFAULT_WINDOW_SPAN
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] offset,
  output logic              in_window,
  output logic              aligned
);

  // Comparing the offset against the span avoids overflow when the window
  // ends at the top of the address space.
  assign offset    = addr - BASE_ADDR;
  assign in_window = (addr >= BASE_ADDR) && (offset < WINDOW_SPAN);
  assign aligned   = is_word_aligned(addr);

endmodule

// File: rtl/periph_bus_initiator.sv
// Single-outstanding initiator between the core load/store path and the
// memory-mapped peripheral register port.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            core request handshake (req_ready is combinational)
//   req_write/req_addr/req_wdata   request payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err              response payload (rdata 0 for writes and errors)
//   address/wr_en/rd_en/wr_data    peripheral strobe side (registered)
//   rd_data                        peripheral read data, sampled only at the read point
// Build option:
//   PERIPH_BUS_POSTED_WRITE_EN     successful writes return no response beat
module periph_bus_initiator
  import periph_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR    = PBI_DEFAULT_BASE_ADDR,
  parameter logic [ADDR_W-1:0] WINDOW_SPAN  = PBI_DEFAULT_WINDOW_SPAN,
  parameter int unsigned       READ_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] address,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] ST_IDLE   = 2'(PBI_IDLE);
  localparam logic [1:0] ST_STROBE = 2'(PBI_STROBE);
  localparam logic [1:0] ST_WAIT   = 2'(PBI_WAIT);
  localparam logic [1:0] ST_RESP   = 2'(PBI_RESP);

  logic [1:0]        state_q, state_d;
  logic              write_q, write_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              wr_en_d, rd_en_d;
  logic              rsp_valid_d;
  pbi_rsp_t          rsp_d;

  logic [ADDR_W-1:0] dec_offset;
  logic              dec_in_window;
  logic              dec_aligned;

  // Window and alignment decode of the incoming request
  periph_addr_decode #(
    .BASE_ADDR   (BASE_ADDR),
    .WINDOW_SPAN (WINDOW_SPAN)
  ) u_decode (
    .addr      (req_addr),
    .offset    (dec_offset),
    .in_window (dec_in_window),
    .aligned   (dec_aligned)
  );

  // Only request path that is not registered; forced low while in reset
  assign req_ready = (state_q == ST_IDLE) && !rst;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    address_d   = address;
    wr_data_d   = wr_data;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_d.err   = rsp_err;
    rsp_d.rdata = rsp_rdata;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          if (dec_in_window && dec_aligned) begin
            state_d   = ST_STROBE;
            address_d = dec_offset;
            wr_en_d   = req_write;
            rd_en_d   = !req_write;
            if (req_write) begin
              wr_data_d = req_wdata;
            end
          end else begin
            // Decode failure: respond directly, never touch the peripheral
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_d.err   = 1'b1;
            rsp_d.rdata = '0;
          end
        end
      end

      ST_STROBE: begin
        if (write_q) begin
`ifdef PERIPH_BUS_POSTED_WRITE_EN
          state_d = ST_IDLE;
`else
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_d.err   = 1'b0;
          rsp_d.rdata = '0;
`endif
        end else if (READ_LATENCY == 0) begin
          // Combinational peripheral: data is valid during the strobe itself
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_d.err   = 1'b0;
          rsp_d.rdata = rd_data;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = LAT_W'(READ_LATENCY - 1);
        end
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_d.err   = 1'b0;
          rsp_d.rdata = rd_data;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access without a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      address   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      address   <= address_d;
      wr_data   <= wr_data_d;
      wr_en     <= wr_en_d;
      rd_en     <= rd_en_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_d.err;
      rsp_rdata <= rsp_d.rdata;
    end
  end

endmodule
